// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter: single-port memory arbiter between instruction fetch and data access,
// data-priority with a bounded starvation counter for the fetch side.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_cancel,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_mode,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [2:0]  m_mode,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);
  localparam logic [2:0] MODE_WORD = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic           fetch_q;
  logic           we_q;
  logic [2:0]     mode_q;
  logic [31:0]    addr_q;
  logic [31:0]    wdata_q;
  logic [31:0]    if_rdata_q;
  logic [31:0]    d_rdata_q;
  logic           cancel_q;
  logic [CW-1:0]  starve_q;

  logic grant_i;
  logic grant_d;

  // A cancel in the same cycle blocks the fetch, so data may still win at the limit.
  assign grant_i = if_req && !if_cancel && (!d_req || (starve_q == STARVE_MAX));
  assign grant_d = d_req && !grant_i;

  always_comb begin
    state_d = state_q;
    m_req   = 1'b0;
    m_we    = 1'b0;
    m_mode  = 3'b000;
    m_addr  = 32'h0;
    m_wdata = 32'h0;
    if_ack  = 1'b0;
    d_ack   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_d)      state_d = BUSY_D;
        else if (grant_i) state_d = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        m_req   = 1'b1;
        m_we    = we_q;
        m_mode  = mode_q;
        m_addr  = addr_q;
        m_wdata = wdata_q;
        if (m_ready) state_d = DONE;
      end
      DONE: begin
        if (fetch_q) if_ack = !cancel_q && !if_cancel;
        else         d_ack  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are forced quiet for every cycle reset is high, not just after the edge.
    if (reset) begin
      m_req   = 1'b0;
      m_we    = 1'b0;
      m_mode  = 3'b000;
      m_addr  = 32'h0;
      m_wdata = 32'h0;
      if_ack  = 1'b0;
      d_ack   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_q    <= 1'b0;
      we_q       <= 1'b0;
      mode_q     <= 3'b000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
      cancel_q   <= 1'b0;
      starve_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            fetch_q  <= 1'b0;
            we_q     <= d_we;
            mode_q   <= d_mode;
            addr_q   <= d_addr;
            wdata_q  <= d_wdata;
            cancel_q <= 1'b0;
          end else if (grant_i) begin
            fetch_q  <= 1'b1;
            we_q     <= 1'b0;
            mode_q   <= MODE_WORD;
            addr_q   <= if_addr;
            wdata_q  <= 32'h0;
            cancel_q <= 1'b0;
          end
          if (!if_req || grant_i)
            starve_q <= '0;
          else if (grant_d && (starve_q != STARVE_MAX))
            starve_q <= starve_q + 1'b1;
        end
        BUSY_I: begin
          if (if_cancel) cancel_q <= 1'b1;
          if (m_ready)   if_rdata_q <= m_rdata;
        end
        BUSY_D: begin
          if (m_ready) d_rdata_q <= m_rdata;
        end
        DONE: cancel_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule
`default_nettype wire
